// File: rtl/ddr_fetch_arbiter_if.sv
// Fetch-arbiter bundle: requester side (req/grant/done/err/beat strobes)
// plus the external bus command/read-data channel.
// master = the arbiter, slave = fetch engines + external bus model.
interface ddr_fetch_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) ();
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
    logic [NUM_REQ-1:0]            grant;
    logic [NUM_REQ-1:0]            done;
    logic [NUM_REQ-1:0]            err;
    logic [NUM_REQ-1:0]            beat_valid;
    logic [DATA_WIDTH-1:0]         beat_data;
    logic                          bus_cmd_valid;
    logic                          bus_cmd_ready;
    logic [ADDR_WIDTH-1:0]         bus_cmd_addr;
    logic [LEN_WIDTH-1:0]          bus_cmd_len;
    logic                          bus_rd_valid;
    logic [DATA_WIDTH-1:0]         bus_rd_data;
    logic                          busy;

    modport master (
        input  req, req_addr, req_len, bus_cmd_ready, bus_rd_valid, bus_rd_data,
        output grant, done, err, beat_valid, beat_data,
               bus_cmd_valid, bus_cmd_addr, bus_cmd_len, busy
    );

    modport slave (
        output req, req_addr, req_len, bus_cmd_ready, bus_rd_valid, bus_rd_data,
        input  grant, done, err, beat_valid, beat_data,
               bus_cmd_valid, bus_cmd_addr, bus_cmd_len, busy
    );
endinterface

// File: rtl/ddr_fetch_arbiter.sv
// Round-robin arbiter sharing the external read bus among the fetch engines.
// One burst at a time: latch request, issue command, steer beats, pulse done.
// Optional watchdog: define ARB_TIMEOUT_EN to abort stalled bursts with err.
module ddr_fetch_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    ddr_fetch_arbiter_if.master io
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_t;

    state_t               state;
    logic [IW-1:0]        rr;      // first index searched next time
    logic [IW-1:0]        owner;   // index of the granted requester
    logic [IW-1:0]        pick;
    logic                 found;
    logic [LEN_WIDTH-1:0] cnt;     // beats received so far in this burst

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd;
`endif

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Round-robin pick: first set req bit at or above rr, wrapping.
    always_comb begin
        int idx;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && io.req[IW'(idx)]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

`ifndef ARB_TIMEOUT_EN
    assign io.err = '0;
`endif

    // Arbitration FSM; all outputs registered. Pulses default low each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            rr               <= '0;
            owner            <= '0;
            cnt              <= '0;
            io.grant         <= '0;
            io.done          <= '0;
            io.beat_valid    <= '0;
            io.beat_data     <= '0;
            io.bus_cmd_valid <= 1'b0;
            io.bus_cmd_addr  <= '0;
            io.bus_cmd_len   <= '0;
            io.busy          <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            io.err           <= '0;
            wd               <= '0;
`endif
        end else begin
            io.done       <= '0;
            io.beat_valid <= '0;
`ifdef ARB_TIMEOUT_EN
            io.err        <= '0;
`endif
            case (state)
                IDLE: begin
                    if (found) begin
                        state            <= CMD;
                        owner            <= pick;
                        io.grant         <= NUM_REQ'(1) << pick;
                        io.bus_cmd_valid <= 1'b1;
                        io.bus_cmd_addr  <= io.req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                        io.bus_cmd_len   <= io.req_len[pick*LEN_WIDTH +: LEN_WIDTH];
                        io.busy          <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        wd               <= '0;
`endif
                    end
                end
                CMD: begin
                    if (io.bus_cmd_ready) begin
                        state            <= XFER;
                        io.bus_cmd_valid <= 1'b0;
                        cnt              <= '0;
`ifdef ARB_TIMEOUT_EN
                        wd               <= '0;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        state            <= IDLE;
                        io.err           <= io.grant;
                        io.grant         <= '0;
                        io.bus_cmd_valid <= 1'b0;
                        io.busy          <= 1'b0;
                        rr               <= next_idx(owner);
                    end else begin
                        wd               <= wd + 1'b1;
`endif
                    end
                end
                XFER: begin
                    if (io.bus_rd_valid) begin
                        io.beat_data  <= io.bus_rd_data[DATA_WIDTH-1:0];
                        io.beat_valid <= io.grant;
`ifdef ARB_TIMEOUT_EN
                        wd            <= '0;
`endif
                        // Compare before increment so len=max never wraps.
                        if (cnt == io.bus_cmd_len) begin
                            state    <= DONE;
                            io.done  <= io.grant;
                            io.grant <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`ifdef ARB_TIMEOUT_EN
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        state    <= IDLE;
                        io.err   <= io.grant;
                        io.grant <= '0;
                        io.busy  <= 1'b0;
                        rr       <= next_idx(owner);
                    end else begin
                        wd <= wd + 1'b1;
`endif
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    io.busy <= 1'b0;
                    rr      <= next_idx(owner);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
